// File: rtl/hazard_pkg.sv
// Shared forwarding-select encodings and MULT/DIV tracker state type for the
// hazard controller.
package hazard_pkg;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_W   = 2'd1;
  localparam logic [1:0] FWD_M   = 2'd2;

  typedef enum logic {
    MD_IDLE,
    MD_BUSY
  } md_state_t;

endpackage

// File: rtl/md_busy_timer.sv
// Tracks the multi-cycle MULT/DIV unit: busy for exactly MULT_LAT or DIV_LAT
// cycles after the issue edge.
module md_busy_timer
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam int unsigned LAT_MAX = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int unsigned CW      = $clog2(LAT_MAX + 1);

  md_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MD_IDLE: begin
        if (start) begin
          state_d = MD_BUSY;
          cnt_d   = is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
        end
      end
      MD_BUSY: begin
        // A start while busy is ignored; the running op always completes.
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = MD_IDLE;
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use/branch/HI-LO stalls, operand forwarding
// selects, exception flush, MULT/DIV busy tracking and a stall-cycle counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W    = 5,
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] rs_D,
  input  logic [REG_W-1:0] rt_D,
  input  logic             use_rs_D,
  input  logic             use_rt_D,
  input  logic             branch_D,
  input  logic             hilo_D,
  input  logic [REG_W-1:0] rs_E,
  input  logic [REG_W-1:0] rt_E,
  input  logic [REG_W-1:0] dst_E,
  input  logic [REG_W-1:0] dst_M,
  input  logic [REG_W-1:0] dst_W,
  input  logic             regwr_E,
  input  logic             regwr_M,
  input  logic             regwr_W,
  input  logic             memtoreg_E,
  input  logic             memtoreg_M,
  input  logic             md_start_E,
  input  logic             md_div_E,
  input  logic             exc_req,
  output logic             stall_F,
  output logic             stall_D,
  output logic             clr_D,
  output logic             clr_E,
  output logic             clr_M,
  output logic             fwd_rs_D,
  output logic             fwd_rt_D,
  output logic [1:0]       fwd_rs_E,
  output logic [1:0]       fwd_rt_E,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  function automatic logic match(input logic [REG_W-1:0] x,
                                 input logic [REG_W-1:0] d,
                                 input logic             we);
    return we && (d != '0) && (x == d);
  endfunction

  function automatic logic [1:0] fwd_e(input logic [REG_W-1:0] x);
    if (match(x, dst_M, regwr_M))      return FWD_M;
    else if (match(x, dst_W, regwr_W)) return FWD_W;
    else                               return FWD_REG;
  endfunction

  logic             lu_stall, br_stall, md_stall, stall;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  md_busy_timer #(
    .MULT_LAT(MULT_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md_timer (
    .clk   (clk),
    .reset (reset),
    .start (md_start_E),
    .is_div(md_div_E),
    .busy  (md_busy)
  );

  always_comb begin
    lu_stall = memtoreg_E &&
               ((use_rs_D && match(rs_D, dst_E, regwr_E)) ||
                (use_rt_D && match(rt_D, dst_E, regwr_E)));
    br_stall = branch_D &&
               ((use_rs_D && (match(rs_D, dst_E, regwr_E) ||
                              (memtoreg_M && match(rs_D, dst_M, regwr_M)))) ||
                (use_rt_D && (match(rt_D, dst_E, regwr_E) ||
                              (memtoreg_M && match(rt_D, dst_M, regwr_M)))));
    md_stall = hilo_D && (md_busy || md_start_E);
    stall    = lu_stall || br_stall || md_stall;

    // Exception redirect flushes D/E/M and releases any hold.
    stall_F = stall && !exc_req;
    stall_D = stall && !exc_req;
    clr_D   = exc_req;
    clr_E   = stall || exc_req;
    clr_M   = exc_req;

    fwd_rs_D = match(rs_D, dst_M, regwr_M && !memtoreg_M);
    fwd_rt_D = match(rt_D, dst_M, regwr_M && !memtoreg_M);
    fwd_rs_E = fwd_e(rs_E);
    fwd_rt_E = fwd_e(rt_E);
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_D && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, multi-cycle
// sequences, and randomized cycles against a cycle-indexed reference model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_D, rt_D, rs_E, rt_E, dst_E, dst_M, dst_W;
  logic       use_rs_D, use_rt_D, branch_D, hilo_D;
  logic       regwr_E, regwr_M, regwr_W, memtoreg_E, memtoreg_M;
  logic       md_start_E, md_div_E, exc_req;
  logic       stall_F, stall_D, clr_D, clr_E, clr_M, fwd_rs_D, fwd_rt_D, md_busy;
  logic [1:0] fwd_rs_E, fwd_rt_E;
  logic [31:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_W(5), .MULT_LAT(5), .DIV_LAT(10), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .use_rs_D(use_rs_D), .use_rt_D(use_rt_D),
    .branch_D(branch_D), .hilo_D(hilo_D),
    .rs_E(rs_E), .rt_E(rt_E), .dst_E(dst_E), .dst_M(dst_M), .dst_W(dst_W),
    .regwr_E(regwr_E), .regwr_M(regwr_M), .regwr_W(regwr_W),
    .memtoreg_E(memtoreg_E), .memtoreg_M(memtoreg_M),
    .md_start_E(md_start_E), .md_div_E(md_div_E), .exc_req(exc_req),
    .stall_F(stall_F), .stall_D(stall_D), .clr_D(clr_D), .clr_E(clr_E), .clr_M(clr_M),
    .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D), .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [4:0]  rs_d, rt_d;
    logic        use_rs, use_rt, br, hilo;
    logic [4:0]  rs_e, rt_e, dst_e, dst_m, dst_w;
    logic        we_e, we_m, we_w, ld_e, ld_m, exc;
    logic [10:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [10:0] comb_out();
    return {stall_F, stall_D, clr_D, clr_E, clr_M, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic zero_inputs();
    rs_D = 0; rt_D = 0; rs_E = 0; rt_E = 0; dst_E = 0; dst_M = 0; dst_W = 0;
    use_rs_D = 0; use_rt_D = 0; branch_D = 0; hilo_D = 0;
    regwr_E = 0; regwr_M = 0; regwr_W = 0; memtoreg_E = 0; memtoreg_M = 0;
    md_start_E = 0; md_div_E = 0; exc_req = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic do_reset();
    next_cycle();
    zero_inputs();
    reset = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b1;
  endtask

  task automatic drive_vec(input vec_t v);
    rs_D = v.rs_d; rt_D = v.rt_d; use_rs_D = v.use_rs; use_rt_D = v.use_rt;
    branch_D = v.br; hilo_D = v.hilo; rs_E = v.rs_e; rt_E = v.rt_e;
    dst_E = v.dst_e; dst_M = v.dst_m; dst_W = v.dst_w;
    regwr_E = v.we_e; regwr_M = v.we_m; regwr_W = v.we_w;
    memtoreg_E = v.ld_e; memtoreg_M = v.ld_m; exc_req = v.exc;
    md_start_E = 0; md_div_E = 0;
  endtask

  // Reference model: MULT/DIV tracked by issue cycle number rather than a countdown.
  longint cyc, md_iss, scnt;
  int     md_lat;
  bit     md_valid;

  function automatic bit m(input logic [4:0] x, input logic [4:0] d, input bit we);
    return we && d != 0 && x == d;
  endfunction

  function automatic logic [1:0] mfwd(input logic [4:0] x);
    if (m(x, dst_M, regwr_M)) return 2;
    if (m(x, dst_W, regwr_W)) return 1;
    return 0;
  endfunction

  initial begin
    bit busy_m, lu, br, md, st;
    logic [10:0] exp;
    zero_inputs();
    reset = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b1;
    settle();
    chk("reset_comb", 64'(comb_out()), 0);
    chk("reset_md_busy", 64'(md_busy), 0);
    chk("reset_stall_cnt", 64'(stall_cnt), 0);

    vecs[0]  = '{0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0, 11'b00000000000, "idle"};
    vecs[1]  = '{2,0,1,0,0,0, 0,0,2,0,0, 1,0,0,1,0,0, 11'b11010000000, "lu_rs"};
    vecs[2]  = '{2,0,0,0,0,0, 0,0,2,0,0, 1,0,0,1,0,0, 11'b00000000000, "lu_unused"};
    vecs[3]  = '{0,7,0,1,0,0, 0,0,7,0,0, 1,0,0,1,0,0, 11'b11010000000, "lu_rt"};
    vecs[4]  = '{0,0,1,1,0,0, 0,0,0,0,0, 1,0,0,1,0,0, 11'b00000000000, "lu_r0"};
    vecs[5]  = '{3,0,1,0,1,0, 0,0,3,0,0, 1,0,0,0,0,0, 11'b11010000000, "br_e"};
    vecs[6]  = '{0,4,0,1,1,0, 0,0,0,4,0, 0,1,0,0,1,0, 11'b11010000000, "br_mload"};
    vecs[7]  = '{4,0,1,0,1,0, 0,0,0,4,0, 0,1,0,0,0,0, 11'b00000100000, "br_mfwd"};
    vecs[8]  = '{0,0,0,0,0,0, 5,0,0,5,5, 0,1,1,0,0,0, 11'b00000001000, "fwdE_m"};
    vecs[9]  = '{0,0,0,0,0,0, 5,0,0,5,5, 0,0,1,0,0,0, 11'b00000000100, "fwdE_w"};
    vecs[10] = '{0,0,0,0,0,0, 0,6,0,6,0, 0,1,0,0,1,0, 11'b00000000010, "fwdE_rt_ld"};
    vecs[11] = '{0,0,0,0,0,0, 0,0,0,0,0, 0,1,1,0,0,0, 11'b00000000000, "fwdE_r0"};
    vecs[12] = '{2,0,1,0,0,0, 0,0,2,0,0, 1,0,0,1,0,1, 11'b00111000000, "exc_lu"};
    vecs[13] = '{0,0,0,0,0,1, 0,0,0,0,0, 0,0,0,0,0,0, 11'b00000000000, "hilo_idle"};

    for (int i = 0; i < 14; i++) begin
      next_cycle();
      drive_vec(vecs[i]);
      settle();
      chk(vecs[i].name, 64'(comb_out()), 64'(vecs[i].exp));
    end

    // Load-use stall, then the load moves to M and forwards to E.
    do_reset();
    rs_D = 2; use_rs_D = 1; dst_E = 2; regwr_E = 1; memtoreg_E = 1;
    settle();
    chk("seq1_stall", 64'({stall_F, stall_D, clr_E}), 64'b111);
    next_cycle();
    dst_E = 0; regwr_E = 0; memtoreg_E = 0;
    dst_M = 2; regwr_M = 1; memtoreg_M = 1; rs_E = 2;
    settle();
    chk("seq1_release", 64'({stall_F, stall_D, clr_E}), 0);
    chk("seq1_fwd_rs_E", 64'(fwd_rs_E), 2);

    // DIV issue with MFHI waiting in D.
    do_reset();
    hilo_D = 1; md_start_E = 1; md_div_E = 1;
    settle();
    chk("seq4_issue_stall", 64'(stall_D), 1);
    chk("seq4_issue_busy", 64'(md_busy), 0);
    for (int i = 1; i <= 10; i++) begin
      next_cycle();
      md_start_E = 0; md_div_E = 0;
      settle();
      chk($sformatf("seq4_busy_%0d", i), 64'(md_busy), 1);
      chk($sformatf("seq4_stall_%0d", i), 64'(stall_D), 1);
    end
    next_cycle();
    settle();
    chk("seq4_done_busy", 64'(md_busy), 0);
    chk("seq4_done_stall", 64'(stall_D), 0);
    chk("seq4_stall_cnt", 64'(stall_cnt), 11);

    // Exception overrides a load-use stall and is not counted.
    do_reset();
    rs_D = 2; use_rs_D = 1; dst_E = 2; regwr_E = 1; memtoreg_E = 1; exc_req = 1;
    settle();
    chk("seq5_outputs", 64'(comb_out()), 64'(11'b00111000000));
    next_cycle();
    zero_inputs();
    settle();
    chk("seq5_stall_cnt", 64'(stall_cnt), 0);

    // Reset during a MULT.
    do_reset();
    md_start_E = 1; hilo_D = 1;
    settle();
    next_cycle(); md_start_E = 0;
    next_cycle();
    next_cycle();
    reset = 0;
    settle();
    chk("seq6_busy_before", 64'(md_busy), 1);
    next_cycle();
    reset = 1; hilo_D = 0;
    settle();
    chk("seq6_busy_after", 64'(md_busy), 0);
    chk("seq6_stall_cnt", 64'(stall_cnt), 0);

    // Randomized cycles against the reference model.
    do_reset();
    cyc = 0; md_valid = 0; scnt = 0; md_iss = 0; md_lat = 0;
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      rs_D = 5'($urandom_range(0, 3)); rt_D = 5'($urandom_range(0, 3));
      rs_E = 5'($urandom_range(0, 3)); rt_E = 5'($urandom_range(0, 3));
      dst_E = 5'($urandom_range(0, 3)); dst_M = 5'($urandom_range(0, 3));
      dst_W = 5'($urandom_range(0, 3));
      use_rs_D = 1'($urandom); use_rt_D = 1'($urandom);
      branch_D = ($urandom_range(0, 3) == 0); hilo_D = 1'($urandom);
      regwr_E = 1'($urandom); regwr_M = 1'($urandom); regwr_W = 1'($urandom);
      memtoreg_E = 1'($urandom); memtoreg_M = 1'($urandom);
      md_start_E = ($urandom_range(0, 3) == 0); md_div_E = 1'($urandom);
      exc_req = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 39) != 0);
      settle();

      busy_m = md_valid && cyc > md_iss && cyc <= md_iss + md_lat;
      lu = memtoreg_E && ((use_rs_D && m(rs_D, dst_E, regwr_E)) ||
                          (use_rt_D && m(rt_D, dst_E, regwr_E)));
      br = branch_D && ((use_rs_D && (m(rs_D, dst_E, regwr_E) ||
                                      (memtoreg_M && m(rs_D, dst_M, regwr_M)))) ||
                        (use_rt_D && (m(rt_D, dst_E, regwr_E) ||
                                      (memtoreg_M && m(rt_D, dst_M, regwr_M)))));
      md = hilo_D && (busy_m || md_start_E);
      st = lu || br || md;
      exp = {st && !exc_req, st && !exc_req, exc_req, st || exc_req, exc_req,
             m(rs_D, dst_M, regwr_M && !memtoreg_M), m(rt_D, dst_M, regwr_M && !memtoreg_M),
             mfwd(rs_E), mfwd(rt_E)};
      chk("rnd_comb", 64'(comb_out()), 64'(exp));
      chk("rnd_md_busy", 64'(md_busy), 64'(busy_m));
      chk("rnd_stall_cnt", 64'(stall_cnt), 64'(scnt));

      if (!reset) begin
        md_valid = 0;
        scnt = 0;
      end else begin
        if (md_start_E && !busy_m) begin
          md_valid = 1;
          md_iss = cyc;
          md_lat = md_div_E ? 10 : 5;
        end
        if (st && !exc_req && scnt < 64'hFFFF_FFFF) scnt++;
      end
      cyc++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
